// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multiport integer register file.
package regfile_pkg;

  typedef enum logic {RF_CLEAR = 1'b0, RF_READY = 1'b1} rf_state_t;

  localparam int RF_XLEN_DEF  = 64;
  localparam int RF_NREGS_DEF = 32;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset sweep sequencer: zeroes registers 1..NREGS-1, then raises ready.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int NREGS = RF_NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          ready_q, ready_d;

  // Next-state: advance the pointer until the last register is cleared; never wrap.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      RF_CLEAR: begin
        if (clr_ptr_q == AW'(NREGS - 1)) begin
          state_d = RF_READY;
          ready_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      RF_READY: begin
        state_d = RF_READY;
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_ptr_d = AW'(1);
        ready_d   = 1'b0;
      end
    endcase
  end

  // Sweep state registers with synchronous reset back to the start of the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign clr_we   = (state_q == RF_CLEAR) && !reset;
  assign clr_addr = clr_ptr_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, dual-write RV64 register file with x0 hardwired, load-port priority and optional bypass.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int XLEN   = RF_XLEN_DEF,
  parameter  int NREGS  = RF_NREGS_DEF,
  parameter  int NRD    = 2,
  parameter  bit BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic                we0,
  input  logic [AW-1:0]       rd0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       rd1,
  input  logic [XLEN-1:0]     wdata1,
  output logic                wr_dropped
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wr0_v, wr1_v;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic            wr_dropped_q, wr_dropped_d;

  regfile_clear_fsm #(.NREGS(NREGS)) u_clear_fsm (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A write is live only once the sweep is done; x0 targets are dropped here.
  assign wr0_v = we0 && (rd0 != AW'(0)) && ready && !reset;
  assign wr1_v = we1 && (rd1 != AW'(0)) && ready && !reset;

  // Per-entry next value: sweep clear, then load port, then ALU port.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      if (clr_we && (clr_addr == AW'(r))) begin
        mem_d[r] = {XLEN{1'b0}};
      end else if (wr1_v && (rd1 == AW'(r))) begin
        mem_d[r] = wdata1;
      end else if (wr0_v && (rd0 == AW'(r))) begin
        mem_d[r] = wdata0;
      end else begin
        mem_d[r] = mem_q[r];
      end
    end
  end

  // Storage array; contents are defined only by the sweep.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Any write request seen before ready is reported one cycle later.
  always_comb begin
    if (ready) begin
      wr_dropped_d = 1'b0;
    end else begin
      wr_dropped_d = we0 | we1;
    end
  end

  // Dropped-write flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_dropped_q <= 1'b0;
    end else begin
      wr_dropped_q <= wr_dropped_d;
    end
  end

  assign wr_dropped = wr_dropped_q;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rval;

    assign ra = rs_addr[g*AW +: AW];

    // Read mux: zero while sweeping or for x0, then forwarded data, then storage.
    always_comb begin
      if (!ready || (ra == AW'(0))) begin
        rval = {XLEN{1'b0}};
      end else if (BYPASS && wr1_v && (rd1 == ra)) begin
        rval = wdata1;
      end else if (BYPASS && wr0_v && (rd0 == ra)) begin
        rval = wdata0;
      end else begin
        rval = mem_q[ra];
      end
    end

    assign rs_data[g*XLEN +: XLEN] = rval;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Table-driven, scoreboarded bench for regfile_multiport (three read ports, bypass on).
module tb_regfile_multiport;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NRD  = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                ready;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic                we0, we1;
  logic [AW-1:0]       rd0, rd1;
  logic [XLEN-1:0]     wdata0, wdata1;
  logic                wr_dropped;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic            we0;
    logic [AW-1:0]   rd0;
    logic [XLEN-1:0] wd0;
    logic            we1;
    logic [AW-1:0]   rd1;
    logic [XLEN-1:0] wd1;
    logic [AW-1:0]   ra [NRD];
    logic [XLEN-1:0] ex [NRD];
  } vec_t;

  vec_t vecs [13];

  regfile_multiport #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .BYPASS(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .rs_addr    (rs_addr),
    .rs_data    (rs_data),
    .we0        (we0),
    .rd0        (rd0),
    .wdata0     (wdata0),
    .we1        (we1),
    .rd1        (rd1),
    .wdata1     (wdata1),
    .wr_dropped (wr_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] port(input int p);
    return rs_data[p*XLEN +: XLEN];
  endfunction

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rs_addr = {a2, a1, a0};
  endtask

  task automatic set_vec(input int i,
                         input logic w0, input logic [AW-1:0] r0, input logic [XLEN-1:0] d0,
                         input logic w1, input logic [AW-1:0] r1, input logic [XLEN-1:0] d1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
    vecs[i].we0 = w0; vecs[i].rd0 = r0; vecs[i].wd0 = d0;
    vecs[i].we1 = w1; vecs[i].rd1 = r1; vecs[i].wd1 = d1;
    vecs[i].ra[0] = a0; vecs[i].ra[1] = a1; vecs[i].ra[2] = a2;
    vecs[i].ex[0] = e0; vecs[i].ex[1] = e1; vecs[i].ex[2] = e2;
  endtask

  initial begin
    logic [XLEN-1:0] big;
    big = 64'hDEAD_BEEF_CAFE_F00D;
    // Each row: one cycle of writes plus same-cycle reads (bypass visible on the write cycle).
    set_vec(0,  1'b1, 5'd5,  64'h1234, 1'b0, 5'd0, 64'h0,    5'd5,  5'd0,  5'd1, 64'h1234, 64'h0,    64'h0);
    set_vec(1,  1'b0, 5'd0,  64'h0,    1'b0, 5'd0, 64'h0,    5'd5,  5'd5,  5'd6, 64'h1234, 64'h1234, 64'h0);
    set_vec(2,  1'b1, 5'd7,  64'hAAAA, 1'b1, 5'd7, 64'hBBBB, 5'd7,  5'd7,  5'd0, 64'hBBBB, 64'hBBBB, 64'h0);
    set_vec(3,  1'b0, 5'd0,  64'h0,    1'b0, 5'd0, 64'h0,    5'd7,  5'd5,  5'd0, 64'hBBBB, 64'h1234, 64'h0);
    set_vec(4,  1'b1, 5'd0,  64'hFFFF, 1'b0, 5'd0, 64'h0,    5'd0,  5'd0,  5'd0, 64'h0,    64'h0,    64'h0);
    set_vec(5,  1'b0, 5'd0,  64'h0,    1'b0, 5'd0, 64'h0,    5'd0,  5'd1,  5'd0, 64'h0,    64'h0,    64'h0);
    set_vec(6,  1'b1, 5'd1,  64'h111,  1'b1, 5'd2, 64'h222,  5'd1,  5'd2,  5'd3, 64'h111,  64'h222,  64'h0);
    set_vec(7,  1'b0, 5'd0,  64'h0,    1'b1, 5'd3, 64'h333,  5'd1,  5'd2,  5'd3, 64'h111,  64'h222,  64'h333);
    set_vec(8,  1'b0, 5'd0,  64'h0,    1'b0, 5'd0, 64'h0,    5'd3,  5'd1,  5'd2, 64'h333,  64'h111,  64'h222);
    set_vec(9,  1'b1, 5'd31, big,      1'b0, 5'd0, 64'h0,    5'd31, 5'd30, 5'd3, big,      64'h0,    64'h333);
    set_vec(10, 1'b1, 5'd9,  64'h55,   1'b1, 5'd0, 64'h66,   5'd9,  5'd0,  5'd31, 64'h55,  64'h0,    big);
    set_vec(11, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0, 64'h0,    5'd9,  5'd31, 5'd7, 64'h55,   big,      64'hBBBB);
    set_vec(12, 1'b1, 5'd0,  64'h9,    1'b1, 5'd0, 64'h9,    5'd0,  5'd9,  5'd5, 64'h0,    64'h55,   64'h1234);

    reset = 1'b1; we0 = 1'b0; we1 = 1'b0; rd0 = 5'd0; rd1 = 5'd0;
    wdata0 = 64'h0; wdata1 = 64'h0; set_rd(5'd1, 5'd2, 5'd3);

    // Test 1: one reset cycle, then the sweep.
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", {63'h0, ready}, 64'h0);
    chk("reset_dropped", {63'h0, wr_dropped}, 64'h0);
    chk("reset_read", port(0), 64'h0);
    for (int k = 1; k <= 31; k++) begin
      set_rd(AW'(k), AW'(k + 1), AW'(k + 2));
      @(posedge clk); @(negedge clk);
      if (k == 30 || k == 31 || k == 1) begin
        chk($sformatf("sweep_ready_%0d", k), {63'h0, ready}, (k == 31) ? 64'h1 : 64'h0);
      end else if (ready !== 1'b0) begin
        chk($sformatf("sweep_ready_%0d", k), {63'h0, ready}, 64'h0);
      end else begin
        total++;
      end
      if (k < 31) chk($sformatf("sweep_read_%0d", k), port(0) | port(1) | port(2), 64'h0);
    end
    for (int r = 0; r < 32; r += 3) begin
      set_rd(AW'(r), AW'(r + 1), AW'(r + 2));
      #1;
      chk($sformatf("swept_zero_%0d", r), port(0) | port(1) | port(2), 64'h0);
    end

    // Tests 2-4, 6: vector table through the scoreboard.
    for (int i = 0; i < 13; i++) begin
      we0 = vecs[i].we0; rd0 = vecs[i].rd0; wdata0 = vecs[i].wd0;
      we1 = vecs[i].we1; rd1 = vecs[i].rd1; wdata1 = vecs[i].wd1;
      set_rd(vecs[i].ra[0], vecs[i].ra[1], vecs[i].ra[2]);
      for (int p = 0; p < NRD; p++) exp_q.push_back(vecs[i].ex[p]);
      exp_q.push_back(64'h0);
      #1;
      for (int p = 0; p < NRD; p++) chk($sformatf("vec%0d_port%0d", i, p), port(p), exp_q.pop_front());
      chk($sformatf("vec%0d_dropped", i), {63'h0, wr_dropped}, exp_q.pop_front());
      @(posedge clk); @(negedge clk);
    end
    we0 = 1'b0; we1 = 1'b0;

    // Test 5: reset mid-sweep, restart, and a dropped write.
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    set_rd(5'd5, 5'd7, 5'd9);
    #1;
    chk("clear_read_zero", port(0) | port(1) | port(2), 64'h0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("mid_sweep_ready", {63'h0, ready}, 64'h0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      if (k == 20) begin we0 = 1'b1; rd0 = 5'd4; wdata0 = 64'h77; end
      @(posedge clk); @(negedge clk);
      we0 = 1'b0;
      if (k == 30 || k == 31) chk($sformatf("resweep_ready_%0d", k), {63'h0, ready}, (k == 31) ? 64'h1 : 64'h0);
      if (k == 20) chk("dropped_pulse", {63'h0, wr_dropped}, 64'h1);
      if (k == 21) chk("dropped_clear", {63'h0, wr_dropped}, 64'h0);
    end
    set_rd(5'd4, 5'd7, 5'd31);
    #1;
    chk("dropped_write_ignored", port(0), 64'h0);
    chk("resweep_reg7", port(1), 64'h0);
    chk("resweep_reg31", port(2), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
